// File: rtl/rwm_sequencer.sv
// rwm_sequencer: drives the frame memory's enable/rw/clear commands, collects read bytes into a framed pixel stream.
// Latency: commands assert the cycle after the phase is entered and drop on the edge that samples RWM_done; pixels lag RWM_valid by 1 cycle.
// Backpressure: none; start/clear_req are ignored while busy, and RWM_valid outside the read phase is ignored.
module rwm_sequencer #(
   parameter int N       = 2,
   parameter int M       = 2,
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       clear_req,
   input  logic       RWM_done,
   input  logic       RWM_valid,
   input  logic [7:0] RWM_data,
   output logic       RWM_enable,
   output logic       rw,
   output logic       clear,
   output logic [7:0] pix_out,
   output logic       pix_valid,
   output logic       pix_first,
   output logic       pix_last,
   output logic       busy,
   output logic       frame_done,
   output logic       error
);

   localparam int P  = N * M;
   localparam int CW = $clog2(P) + 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_WR, S_GAP, S_RD, S_FIN, S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] wd_q, wd_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          enable_q, rw_q, clear_q;
   logic [7:0]    pix_out_q;
   logic          pix_valid_q, pix_first_q, pix_last_q;
   logic          busy_q, frame_done_q, error_q;

   logic          in_phase;
   logic          rd_byte;
   logic [WW-1:0] wd_inc;
   logic          timeout_hit;
   logic [CW:0]   cnt_total;
   logic          stay;

   // A command phase is one where the memory is being driven and the watchdog runs.
   assign in_phase    = (state_q == S_CLR) || (state_q == S_WR) || (state_q == S_RD);
   assign rd_byte     = (state_q == S_RD) && RWM_valid;
   assign wd_inc      = wd_q + 1'b1;
   // Done takes priority over an expiring watchdog in the same cycle.
   assign timeout_hit = in_phase && !RWM_done && (wd_inc == WW'(TIMEOUT));
   // Count including the byte arriving this cycle, one bit wider so a saturated counter can never alias P.
   assign cnt_total   = {1'b0, cnt_q} + {{CW{1'b0}}, rd_byte};
   // Commands stay asserted only while remaining in the same phase; this drops enable on the edge that sees done.
   assign stay        = (state_d == state_q) && in_phase;

   // Next-state, watchdog and byte-counter logic.
   always_comb begin
      state_d = state_q;
      wd_d    = wd_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (clear_req)  state_d = S_CLR;
            else if (start) state_d = S_WR;
         end
         S_CLR: begin
            if (RWM_done)         state_d = S_IDLE;
            else if (timeout_hit) state_d = S_ERR;
         end
         S_WR: begin
            if (RWM_done)         state_d = S_GAP;
            else if (timeout_hit) state_d = S_ERR;
         end
         S_GAP: state_d = S_RD;
         S_RD: begin
            if (RWM_done)         state_d = (cnt_total == (CW+1)'(P)) ? S_FIN : S_ERR;
            else if (timeout_hit) state_d = S_ERR;
         end
         S_FIN:   state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) wd_d = '0;
      else if (in_phase)      wd_d = wd_inc;

      // Outside RD the counter sits at zero, so it is already cleared on RD entry.
      if (state_q != S_RD)                        cnt_d = '0;
      else if (rd_byte && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   // State, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wd_q         <= '0;
         cnt_q        <= '0;
         enable_q     <= 1'b0;
         rw_q         <= 1'b0;
         clear_q      <= 1'b0;
         pix_out_q    <= '0;
         pix_valid_q  <= 1'b0;
         pix_first_q  <= 1'b0;
         pix_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wd_q         <= wd_d;
         cnt_q        <= cnt_d;
         enable_q     <= stay;
         rw_q         <= stay && (state_q == S_WR);
         clear_q      <= stay && (state_q == S_CLR);
         pix_valid_q  <= rd_byte;
         if (rd_byte) pix_out_q <= RWM_data;
         pix_first_q  <= rd_byte && (cnt_q == '0);
         pix_last_q   <= rd_byte && (cnt_q == CW'(P - 1));
         busy_q       <= (state_d != S_IDLE);
         frame_done_q <= (state_q == S_FIN);
         if ((state_q == S_IDLE) && (state_d != S_IDLE)) error_q <= 1'b0;
         else if (state_d == S_ERR)                      error_q <= 1'b1;
      end
   end

   assign RWM_enable = enable_q;
   assign rw         = rw_q;
   assign clear      = clear_q;
   assign pix_out    = pix_out_q;
   assign pix_valid  = pix_valid_q;
   assign pix_first  = pix_first_q;
   assign pix_last   = pix_last_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_rwm_sequencer.sv
// Directed bench for rwm_sequencer with N=M=2, TIMEOUT=16.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-derived constants per step.
module tb_rwm_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       clear_req;
   logic       RWM_done;
   logic       RWM_valid;
   logic [7:0] RWM_data;
   logic       RWM_enable;
   logic       rw;
   logic       clear;
   logic [7:0] pix_out;
   logic       pix_valid;
   logic       pix_first;
   logic       pix_last;
   logic       busy;
   logic       frame_done;
   logic       error;

   logic [16:0] outs;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   rwm_sequencer #(.N(2), .M(2), .TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .clear_req  (clear_req),
      .RWM_done   (RWM_done),
      .RWM_valid  (RWM_valid),
      .RWM_data   (RWM_data),
      .RWM_enable (RWM_enable),
      .rw         (rw),
      .clear      (clear),
      .pix_out    (pix_out),
      .pix_valid  (pix_valid),
      .pix_first  (pix_first),
      .pix_last   (pix_last),
      .busy       (busy),
      .frame_done (frame_done),
      .error      (error)
   );

   assign outs = {RWM_enable, rw, clear, pix_out, pix_valid, pix_first, pix_last, busy, frame_done, error};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start, let the write phase finish after a few cycles, pass GAP, end with RD enable high.
   task automatic start_to_rd();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      RWM_done = 1'b1;
      tick();
      RWM_done = 1'b0;
      tick();
      tick();
   endtask

   // Stream 11,22,33,44 with done on the last byte and check the framed output.
   task automatic read_frame(input string tag);
      logic [7:0] bytes [4];
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         RWM_valid = 1'b1;
         RWM_data  = bytes[i];
         RWM_done  = (i == 3);
         tick();
         check({tag, "_pix"}, 32'(pix_out), 32'(bytes[i]));
         check({tag, "_vfl"}, 32'({pix_valid, pix_first, pix_last}),
               32'({1'b1, (i == 0), (i == 3)}));
         check({tag, "_fd_early"}, 32'(frame_done), 32'd0);
      end
      check({tag, "_en_drop"}, 32'(RWM_enable), 32'd0);
      RWM_valid = 1'b0;
      RWM_done  = 1'b0;
      tick();
      check({tag, "_fd"}, 32'({frame_done, pix_valid, error, RWM_enable}), 32'b1000);
      tick();
      check({tag, "_fd_end"}, 32'({frame_done, busy}), 32'd0);
   endtask

   initial begin
      int  fd_cnt;
      logic seen;
      rst = 1'b1; start = 1'b0; clear_req = 1'b0;
      RWM_done = 1'b0; RWM_valid = 1'b0; RWM_data = 8'h00;
      tick();
      tick();
      check("reset_outs", 32'(outs), 32'd0);
      rst = 1'b0;
      tick();
      check("idle_outs", 32'(outs), 32'd0);

      // Normal frame.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_en_delay", 32'(RWM_enable), 32'd0);
      tick();
      check("t1_wr_cmd", 32'({RWM_enable, rw, clear}), 32'b110);
      tick();
      RWM_done = 1'b1;
      tick();
      RWM_done = 1'b0;
      check("t1_wr_done", 32'({RWM_enable, rw, busy}), 32'b001);
      tick();
      check("t1_gap", 32'({RWM_enable, busy}), 32'b01);
      tick();
      check("t1_rd_cmd", 32'({RWM_enable, rw, clear}), 32'b100);
      read_frame("t1");

      // Clear wins over start.
      clear_req = 1'b1;
      start     = 1'b1;
      tick();
      clear_req = 1'b0;
      start     = 1'b0;
      check("t2_busy", 32'(busy), 32'd1);
      tick();
      check("t2_clr_cmd", 32'({RWM_enable, rw, clear}), 32'b101);
      tick();
      RWM_done = 1'b1;
      tick();
      RWM_done = 1'b0;
      check("t2_done", 32'({RWM_enable, clear, busy}), 32'b000);
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen = seen | rw | busy | RWM_enable;
      end
      check("t2_no_wr", 32'(seen), 32'd0);

      // Write phase timeout.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (15) tick();
      check("t3_pre_to", 32'({error, RWM_enable, busy}), 32'b011);
      tick();
      check("t3_timeout", 32'({error, RWM_enable, busy}), 32'b101);
      tick();
      check("t3_idle", 32'({error, busy}), 32'b10);

      // Short read: start clears error, 3 bytes then done.
      start_to_rd();
      check("t4_err_clr", 32'(error), 32'd0);
      for (int i = 0; i < 3; i++) begin
         RWM_valid = 1'b1;
         RWM_data  = 8'(i + 1);
         RWM_done  = (i == 2);
         tick();
      end
      RWM_valid = 1'b0;
      RWM_done  = 1'b0;
      check("t4_err", 32'({error, frame_done, RWM_enable}), 32'b100);
      tick();
      check("t4_after", 32'({error, frame_done, busy}), 32'b100);

      // Start during RD is ignored.
      start_to_rd();
      start     = 1'b1;
      RWM_valid = 1'b1;
      RWM_data  = 8'h11;
      tick();
      start = 1'b0;
      RWM_data = 8'h22;
      tick();
      RWM_data = 8'h33;
      tick();
      RWM_data = 8'h44;
      RWM_done = 1'b1;
      tick();
      RWM_valid = 1'b0;
      RWM_done  = 1'b0;
      fd_cnt = 0;
      seen   = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (frame_done) fd_cnt++;
         seen = seen | rw;
      end
      check("t5_fd_count", 32'(fd_cnt), 32'd1);
      check("t5_no_wr", 32'({seen, busy, error}), 32'd0);

      // Reset mid-read, then a clean frame.
      start_to_rd();
      RWM_valid = 1'b1;
      RWM_data  = 8'h5A;
      tick();
      rst       = 1'b1;
      RWM_valid = 1'b0;
      tick();
      check("t6_rst_outs", 32'(outs), 32'd0);
      rst = 1'b0;
      tick();
      start_to_rd();
      read_frame("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
